// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, tracks in-flight
// responses, buffers kept responses in a FIFO and discards stale ones after a redirect.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_o_req,
  output logic [63:0] imem_o_addr,
  input  logic        imem_i_gnt,
  input  logic        imem_i_rvalid,
  input  logic [31:0] imem_i_rdata,
  input  logic        redirect_i_valid,
  input  logic [63:0] redirect_i_pc,
  output logic        fetch_o_valid,
  output logic [31:0] fetch_o_instr,
  output logic [63:0] fetch_o_pc,
  input  logic        decode_i_ready
);

  localparam int            AW    = $clog2(DEPTH);
  localparam int            CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

  logic [63:0]   pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] occupancy;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [63:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];

  logic          transfer;
  logic          discard;
  logic          push;
  logic          pop;
  logic [CW:0]   committed;
  logic [63:0]   redirect_target;
  logic [CW-1:0] inflight_after_resp;

  // Requests are throttled on registered counts only, so a pop never frees a slot in the same cycle.
  assign committed           = {1'b0, inflight} + {1'b0, occupancy};
  assign redirect_target     = redirect_i_pc & ~64'd3;
  assign imem_o_req          = rst & ~redirect_i_valid & (committed < LIMIT);
  assign imem_o_addr         = pc & ~64'd3;
  assign transfer            = imem_o_req & imem_i_gnt;
  assign discard             = imem_i_rvalid & (drop != '0);
  assign push                = imem_i_rvalid & ~discard & ~redirect_i_valid;
  assign fetch_o_valid       = (occupancy != '0);
  assign pop                 = fetch_o_valid & decode_i_ready & ~redirect_i_valid;
  assign fetch_o_instr       = buf_instr[rd_ptr];
  assign fetch_o_pc          = buf_pc[rd_ptr];
  assign inflight_after_resp = inflight - CW'(imem_i_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(transfer) - CW'(imem_i_rvalid);
      if (redirect_i_valid) begin
        // Everything still outstanding belongs to the old path, including earlier stale requests.
        pc      <= redirect_target;
        resp_pc <= redirect_target;
        drop    <= inflight_after_resp;
      end else begin
        if (transfer) pc <= pc + 64'd4;
        if (push) resp_pc <= resp_pc + 64'd4;
        if (discard) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (redirect_i_valid) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= resp_pc;
      buf_instr[wr_ptr] <= imem_i_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory with configurable latency plus a
// queue-level model of the expected fetch stream, checked every cycle.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_o_req;
  logic [63:0] imem_o_addr;
  logic        imem_i_gnt;
  logic        imem_i_rvalid;
  logic [31:0] imem_i_rdata;
  logic        redirect_i_valid;
  logic [63:0] redirect_i_pc;
  logic        fetch_o_valid;
  logic [31:0] fetch_o_instr;
  logic [63:0] fetch_o_pc;
  logic        decode_i_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_o_req       (imem_o_req),
    .imem_o_addr      (imem_o_addr),
    .imem_i_gnt       (imem_i_gnt),
    .imem_i_rvalid    (imem_i_rvalid),
    .imem_i_rdata     (imem_i_rdata),
    .redirect_i_valid (redirect_i_valid),
    .redirect_i_pc    (redirect_i_pc),
    .fetch_o_valid    (fetch_o_valid),
    .fetch_o_instr    (fetch_o_instr),
    .fetch_o_pc       (fetch_o_pc),
    .decode_i_ready   (decode_i_ready)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] pc;
    int          due;
    logic        stale;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        mq[$];
  ent_t        fq[$];
  logic [63:0] pop_log[$];
  logic [63:0] exp_fetch_pc;
  int          cyc;
  int          lat;
  int          grants;
  int          n_checks;
  int          n_fail;
  req_t        resp;
  logic        keep;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF ^ {a[47:32], 16'h0000};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory and reference model: every granted fetch is queued; a redirect marks all outstanding fetches stale.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      mq.delete();
      fq.delete();
      exp_fetch_pc = RESET_PC;
      grants = 0;
    end else begin
      keep = 1'b0;
      if (imem_i_rvalid && mq.size() > 0) begin
        resp = mq.pop_front();
        keep = !resp.stale && !redirect_i_valid;
      end
      if (fq.size() > 0 && decode_i_ready && !redirect_i_valid) begin
        pop_log.push_back(fq[0].pc);
        void'(fq.pop_front());
      end
      if (keep) begin
        check_output("push_not_full", 64'(fq.size() < DEPTH), 64'd1);
        fq.push_back('{resp.pc, mem_fn(resp.pc)});
      end
      if (redirect_i_valid) begin
        fq.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
        exp_fetch_pc = redirect_i_pc & ~64'd3;
      end else if (imem_o_req && imem_i_gnt) begin
        mq.push_back('{imem_o_addr, exp_fetch_pc, cyc + lat - 1, 1'b0});
        exp_fetch_pc = exp_fetch_pc + 64'd4;
        grants++;
      end
    end
    #1;
    if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_i_rvalid = 1'b1;
      imem_i_rdata  = mem_fn(mq[0].addr);
    end else begin
      imem_i_rvalid = 1'b0;
      imem_i_rdata  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("reset_req", 64'(imem_o_req), 64'd0);
      check_output("reset_valid", 64'(fetch_o_valid), 64'd0);
    end else begin
      check_output("req", 64'(imem_o_req), 64'(!redirect_i_valid && (mq.size() + fq.size() < DEPTH)));
      if (imem_o_req) check_output("addr", imem_o_addr, exp_fetch_pc);
      check_output("valid", 64'(fetch_o_valid), 64'(fq.size() != 0));
      if (fq.size() != 0) begin
        check_output("head_pc", fetch_o_pc, fq[0].pc);
        check_output("head_instr", 64'(fetch_o_instr), 64'(fq[0].instr));
      end
    end
  end

  // Leaves the bench 1ns into the first cycle after reset release.
  task automatic do_reset(input int latency);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = latency;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pop_log.delete();
  endtask

  task automatic apply_stimulus(input logic gnt, input logic ready);
    imem_i_gnt     = gnt;
    decode_i_ready = ready;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int left;
    left = budget;
    while (pop_log.size() < n && left > 0) begin
      @(posedge clk);
      #2;
      left--;
    end
    if (pop_log.size() < n) check_output("pop_timeout", 64'(pop_log.size()), 64'(n));
  endtask

  logic [39:0] gnt_pat;
  logic [39:0] ready_pat;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat      = 1;
    grants   = 0;
    rst              = 1'b0;
    imem_i_rvalid    = 1'b0;
    imem_i_rdata     = 32'h0;
    redirect_i_valid = 1'b0;
    redirect_i_pc    = 64'h0;
    apply_stimulus(1'b1, 1'b1);

    // Sequential delivery after reset
    do_reset(1);
    @(negedge clk);
    check_output("first_req", 64'(imem_o_req), 64'd1);
    check_output("first_addr", imem_o_addr, 64'h8000_0000);
    wait_pops(3, 40);
    if (pop_log.size() >= 3) begin
      check_output("seq_pc0", pop_log[0], 64'h8000_0000);
      check_output("seq_pc1", pop_log[1], 64'h8000_0004);
      check_output("seq_pc2", pop_log[2], 64'h8000_0008);
    end

    // Decode stalled: buffer fills, then a single pop frees one request slot
    apply_stimulus(1'b1, 1'b0);
    do_reset(1);
    repeat (8) @(posedge clk);
    #1;
    check_output("stall_grants", 64'(grants), 64'd2);
    @(negedge clk);
    check_output("stall_req", 64'(imem_o_req), 64'd0);
    check_output("stall_valid", 64'(fetch_o_valid), 64'd1);
    check_output("stall_pc", fetch_o_pc, 64'h8000_0000);
    check_output("stall_instr", 64'(fetch_o_instr), 64'(mem_fn(64'h8000_0000)));
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b1);
    @(negedge clk);
    check_output("pop_cycle_req", 64'(imem_o_req), 64'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0);
    @(negedge clk);
    check_output("after_pop_req", 64'(imem_o_req), 64'd1);
    check_output("after_pop_pc", fetch_o_pc, 64'h8000_0004);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b1);

    // Grant withheld: request and address hold
    apply_stimulus(1'b0, 1'b1);
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_req", 64'(imem_o_req), 64'd1);
      check_output("hold_addr", imem_o_addr, 64'h8000_0000);
    end
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b1);
    wait_pops(1, 20);
    if (pop_log.size() >= 1) check_output("hold_pc0", pop_log[0], 64'h8000_0000);

    // Redirect with two fetches in flight: both discarded
    do_reset(3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    redirect_i_valid = 1'b1;
    redirect_i_pc    = 64'h8000_1002;
    pop_log.delete();
    @(negedge clk);
    check_output("redir_inflight", 64'(grants), 64'd2);
    check_output("redir_req", 64'(imem_o_req), 64'd0);
    @(posedge clk);
    #1;
    redirect_i_valid = 1'b0;
    @(negedge clk);
    check_output("redir_next_valid", 64'(fetch_o_valid), 64'd0);
    wait_pops(2, 40);
    if (pop_log.size() >= 2) begin
      check_output("redir_pc0", pop_log[0], 64'h8000_1000);
      check_output("redir_pc1", pop_log[1], 64'h8000_1004);
    end

    // Redirect coinciding with a response and a pop
    do_reset(1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    redirect_i_valid = 1'b1;
    redirect_i_pc    = 64'h8000_2000;
    pop_log.delete();
    @(negedge clk);
    check_output("coinc_rvalid", 64'(imem_i_rvalid), 64'd1);
    check_output("coinc_valid", 64'(fetch_o_valid), 64'd1);
    check_output("coinc_req", 64'(imem_o_req), 64'd0);
    @(posedge clk);
    #1;
    redirect_i_valid = 1'b0;
    @(negedge clk);
    check_output("coinc_next_valid", 64'(fetch_o_valid), 64'd0);
    wait_pops(1, 30);
    if (pop_log.size() >= 1) check_output("coinc_pc0", pop_log[0], 64'h8000_2000);

    // Asynchronous reset with two fetches in flight
    do_reset(3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check_output("async_req", 64'(imem_o_req), 64'd0);
    check_output("async_valid", 64'(fetch_o_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pop_log.delete();
    @(negedge clk);
    check_output("restart_req", 64'(imem_o_req), 64'd1);
    check_output("restart_addr", imem_o_addr, RESET_PC);
    wait_pops(2, 40);
    if (pop_log.size() >= 2) begin
      check_output("restart_pc0", pop_log[0], 64'h8000_0000);
      check_output("restart_pc1", pop_log[1], 64'h8000_0004);
    end

    // Mixed grant/ready pattern with back-to-back redirects while draining
    gnt_pat   = 40'hF7_DBEF_6FBD;
    ready_pat = 40'hDB_7F3E_DF77;
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(gnt_pat[i], ready_pat[i]);
      redirect_i_valid = (i == 15 || i == 17 || i == 30);
      redirect_i_pc    = 64'h9000_0000 + 64'(i * 64) + 64'd2;
      @(posedge clk);
      #1;
    end
    redirect_i_valid = 1'b0;
    apply_stimulus(1'b1, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
